// File: rtl/simple_bus_arbiter_if.sv
// Requester-side and simple-bus-side signals of the round-robin bus arbiter.
// The arbiter connects through the master modport; the requesters and slave use the slave modport.
interface simple_bus_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            done;
    logic [NUM_REQ-1:0]            rvalid;
    logic [DATA_WIDTH-1:0]         rdata;
    logic                          busy;
    logic [ADDR_WIDTH-1:0]         wrAddr;
    logic [DATA_WIDTH-1:0]         wrData;
    logic                          wr;
    logic [ADDR_WIDTH-1:0]         rdAddr;
    logic [DATA_WIDTH-1:0]         rdData;
    logic                          rd;

    modport master (
        input  req, req_we, req_addr, req_wdata, rdData,
        output gnt, done, rvalid, rdata, busy, wrAddr, wrData, wr, rdAddr, rd
    );

    modport slave (
        output req, req_we, req_addr, req_wdata, rdData,
        input  gnt, done, rvalid, rdata, busy, wrAddr, wrData, wr, rdAddr, rd
    );
endinterface

// File: rtl/simple_bus_arbiter.sv
// Round-robin arbiter serialising NUM_REQ requesters onto one simple-bus slave port.
//  state     | meaning
//  ST_IDLE   | pick next requester after the last grant, pulse gnt, latch its transaction
//  ST_ISSUE  | drive latched address/data; one-cycle wr (with done) or rd strobe
//  ST_RDWAIT | slave read data valid; captured into rdata, rvalid follows in next IDLE
module simple_bus_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                 S_AXI_ACLK,
    input  logic                 S_AXI_ARESETN,
    simple_bus_arbiter_if.master bus
);
    localparam int                 IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] ONE   = NUM_REQ'(1);
    localparam logic [IDX_W-1:0]   LAST  = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_RDWAIT = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [IDX_W-1:0]      r_ptr;
    logic [IDX_W-1:0]      r_owner;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rvalid_pend;

    logic                  w_any;
    logic [IDX_W-1:0]      w_winner;
    logic                  w_grant;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;

    // Later iterations overwrite earlier ones, so the candidate nearest after r_ptr wins.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (bus.req[(int'(r_ptr) + k) % NUM_REQ]) begin
                w_any    = 1'b1;
                w_winner = IDX_W'((int'(r_ptr) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == IDX_W'(i)) begin
                w_sel_we    = bus.req_we[i];
                w_sel_addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // gnt is combinational, so gate it with reset to keep it quiet while reset is held.
    assign w_grant = (r_state == ST_IDLE) && w_any && S_AXI_ARESETN;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) r_state <= ST_IDLE;
        else                r_state <= w_next;
    end

    always_comb begin
        w_next = ST_IDLE;
        case (r_state)
            ST_IDLE:   w_next = w_any ? ST_ISSUE : ST_IDLE;
            ST_ISSUE:  w_next = r_we ? ST_IDLE : ST_RDWAIT;
            ST_RDWAIT: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_ptr         <= LAST;
            r_owner       <= '0;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_rdata       <= '0;
            r_rvalid_pend <= 1'b0;
        end else begin
            if (w_grant) begin
                r_ptr   <= w_winner;
                r_owner <= w_winner;
                r_we    <= w_sel_we;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
            end
            if (r_state == ST_RDWAIT) r_rdata <= bus.rdData;
            r_rvalid_pend <= (r_state == ST_RDWAIT);
        end
    end

    always_comb begin
        bus.gnt    = '0;
        bus.done   = '0;
        bus.rvalid = '0;
        bus.wr     = 1'b0;
        bus.rd     = 1'b0;
        bus.wrAddr = '0;
        bus.rdAddr = '0;
        bus.wrData = '0;
        bus.busy   = (r_state != ST_IDLE);
        bus.rdata  = r_rdata;
        if (w_grant) bus.gnt = ONE << w_winner;
        if (r_rvalid_pend) bus.rvalid = ONE << r_owner;
        if (r_state == ST_ISSUE) begin
            bus.wrAddr = r_addr;
            bus.rdAddr = r_addr;
            bus.wrData = r_wdata;
            bus.wr     = r_we;
            bus.rd     = !r_we;
            if (r_we) bus.done = ONE << r_owner;
        end
    end
endmodule

// File: tb/tb_simple_bus_arbiter.sv
// Randomised and directed bench for simple_bus_arbiter against a transaction-level model
// that schedules expected slave strobes and responses by cycle number.
module tb_simple_bus_arbiter;
    localparam int N  = 2;
    localparam int AW = 6;
    localparam int DW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    simple_bus_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    simple_bus_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(rst_n),
        .bus          (bus)
    );

    // register-model slave: write on wr, registered read data the cycle after rd
    bit [DW-1:0] slv_mem [64];
    always @(posedge clk) begin
        if (bus.wr) slv_mem[bus.wrAddr] <= bus.wrData;
        if (bus.rd) bus.rdData <= slv_mem[bus.rdAddr];
    end

    typedef struct packed {
        logic [N-1:0]  done;
        logic [N-1:0]  rvalid;
        logic          wr;
        logic          rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic          upd;
        logic [DW-1:0] rdv;
    } exp_t;

    exp_t          exp_at [int];
    bit [DW-1:0]   mem_m [64];
    int            cyc, idle_at, ptr;
    logic [DW-1:0] rdata_m;
    logic [N-1:0]  p_req, p_we, p_hold;
    logic [AW-1:0] p_addr [N];
    logic [DW-1:0] p_data [N];
    logic [N-1:0]  g_m;
    bit            rand_mode;
    int            checks, errors;

    logic [N-1:0]  s_gnt, s_done, s_rvalid;
    logic          s_wr, s_rd, s_busy;
    logic [DW-1:0] s_rdata;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic drive();
        bus.req    = p_req;
        bus.req_we = p_we;
        for (int i = 0; i < N; i++) begin
            bus.req_addr[i*AW +: AW]  = p_addr[i];
            bus.req_wdata[i*DW +: DW] = p_data[i];
        end
    endtask

    task automatic post(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        p_req[i]  = 1'b1;
        p_we[i]   = we;
        p_addr[i] = a;
        p_data[i] = d;
        drive();
    endtask

    // one clock: check at negedge against the model, then update requests after posedge
    task automatic step();
        exp_t e, e1, e3;
        int   w;
        logic busy_e;
        @(negedge clk);
        e = '0; g_m = '0; busy_e = 1'b0;
        if (!rst_n) begin
            exp_at.delete();
            idle_at = cyc + 1;
            ptr     = N - 1;
            rdata_m = '0;
        end else begin
            if (exp_at.exists(cyc)) begin
                e = exp_at[cyc];
                exp_at.delete(cyc);
            end
            if (e.upd) rdata_m = e.rdv;
            busy_e = (cyc < idle_at);
            if (!busy_e && p_req != '0) begin
                w = -1;
                for (int k = 1; k <= N; k++)
                    if (w < 0 && p_req[(ptr + k) % N]) w = (ptr + k) % N;
                g_m[w] = 1'b1;
                ptr    = w;
                e1 = exp_at.exists(cyc + 1) ? exp_at[cyc + 1] : '0;
                e1.addr = p_addr[w];
                e1.wd   = p_data[w];
                if (p_we[w]) begin
                    mem_m[p_addr[w]] = p_data[w];
                    e1.wr      = 1'b1;
                    e1.done[w] = 1'b1;
                    idle_at    = cyc + 2;
                end else begin
                    e1.rd = 1'b1;
                    e3 = exp_at.exists(cyc + 3) ? exp_at[cyc + 3] : '0;
                    e3.rvalid[w] = 1'b1;
                    e3.upd       = 1'b1;
                    e3.rdv       = mem_m[p_addr[w]];
                    exp_at[cyc + 3] = e3;
                    idle_at = cyc + 3;
                end
                exp_at[cyc + 1] = e1;
            end
        end
        s_gnt = bus.gnt; s_done = bus.done; s_rvalid = bus.rvalid;
        s_wr = bus.wr; s_rd = bus.rd; s_busy = bus.busy; s_rdata = bus.rdata;
        check("gnt",    bus.gnt,    g_m);
        check("done",   bus.done,   e.done);
        check("rvalid", bus.rvalid, e.rvalid);
        check("wr",     bus.wr,     e.wr);
        check("rd",     bus.rd,     e.rd);
        check("busy",   bus.busy,   busy_e);
        check("wrAddr", bus.wrAddr, (e.wr || e.rd) ? e.addr : '0);
        check("rdAddr", bus.rdAddr, (e.wr || e.rd) ? e.addr : '0);
        check("wrData", bus.wrData, (e.wr || e.rd) ? e.wd : '0);
        check("rdata",  bus.rdata,  rdata_m);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (g_m[i]) begin
                if (p_hold[i]) begin
                    p_addr[i] = AW'($urandom);
                    p_data[i] = $urandom;
                    if (rand_mode) begin
                        p_we[i]   = $urandom_range(0, 1) == 1;
                        p_hold[i] = $urandom_range(0, 3) == 0;
                    end
                end else begin
                    p_req[i] = 1'b0;
                end
            end else if (rand_mode && !p_req[i] && $urandom_range(0, 99) < 30) begin
                p_req[i]  = 1'b1;
                p_we[i]   = $urandom_range(0, 1) == 1;
                p_addr[i] = AW'($urandom);
                p_data[i] = $urandom;
                p_hold[i] = $urandom_range(0, 3) == 0;
            end
        end
        drive();
        cyc++;
    endtask

    task automatic wait_quiet();
        logic pend;
        pend = 1'b1;
        for (int n = 0; n < 60 && pend; n++) begin
            step();
            pend = (p_req != '0) || (cyc < idle_at) || (exp_at.size() != 0);
        end
        check("drain_timeout", pend, 1'b0);
    endtask

    logic [N-1:0] seq [8];
    int           cnt1, cnt0, seen;

    initial begin
        checks = 0; errors = 0; cyc = 0; idle_at = 0; ptr = N - 1; rdata_m = '0;
        rand_mode = 1'b0; p_req = '0; p_we = '0; p_hold = '0;
        for (int i = 0; i < N; i++) begin p_addr[i] = '0; p_data[i] = '0; end
        drive();

        // reset state, then a single write from requester 1
        repeat (3) step();
        rst_n = 1'b1;
        post(1, 1'b1, 6'h08, 32'hDEADBEEF);
        step(); check("t1_gnt", s_gnt, 2'b10);
        step(); check("t1_wr", s_wr, 1'b1); check("t1_done", s_done, 2'b10);
        step(); check("t1_busy_low", s_busy, 1'b0);
        wait_quiet();

        // read from requester 0 after seeding the location
        post(1, 1'b1, 6'h04, 32'h12345678);
        wait_quiet();
        post(0, 1'b0, 6'h04, 32'h0);
        step(); check("t2_gnt", s_gnt, 2'b01);
        step(); check("t2_rd", s_rd, 1'b1);
        step();
        step(); check("t2_rvalid", s_rvalid, 2'b01); check("t2_rdata", s_rdata, 32'h12345678);
        repeat (3) step();
        check("t2_rdata_hold", s_rdata, 32'h12345678);
        wait_quiet();

        // write by 0, read back by 1
        post(0, 1'b1, 6'h10, 32'hA5A5A5A5);
        wait_quiet();
        post(1, 1'b0, 6'h10, 32'h0);
        seen = 0;
        for (int n = 0; n < 8 && seen == 0; n++) begin
            step();
            if (s_rvalid != '0) seen = 1;
        end
        check("t6_rvalid", s_rvalid, 2'b10);
        check("t6_rdata", s_rdata, 32'hA5A5A5A5);
        wait_quiet();

        // lone requester 1 holding reads
        p_hold = 2'b10;
        post(1, 1'b0, 6'h10, 32'h0);
        cnt1 = 0; cnt0 = 0;
        for (int n = 0; n < 12; n++) begin
            step();
            if (s_gnt[1]) cnt1++;
            if (s_gnt[0]) cnt0++;
        end
        check("t4_gnt1_count", cnt1, 4);
        check("t4_gnt0_count", cnt0, 0);
        p_hold = '0;
        wait_quiet();

        // both hold writes from a reset release
        rst_n = 1'b0;
        step();
        p_hold = 2'b11;
        post(0, 1'b1, 6'h20, $urandom);
        post(1, 1'b1, 6'h21, $urandom);
        rst_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            step();
            seq[n] = s_gnt;
            check("t3_wr_rd_excl", s_wr & s_rd, 1'b0);
        end
        check("t3_gnt0", seq[0], 2'b01);
        check("t3_gnt2", seq[2], 2'b10);
        check("t3_gnt4", seq[4], 2'b01);
        check("t3_gnt6", seq[6], 2'b10);
        check("t3_gap", seq[1] | seq[3] | seq[5] | seq[7], 2'b00);
        p_hold = '0;
        wait_quiet();

        // reset asserted during RDWAIT drops the read
        post(0, 1'b0, 6'h10, 32'h0);
        step();
        step();
        #1 rst_n = 1'b0;
        post(0, 1'b1, 6'h30, 32'h11111111);
        post(1, 1'b1, 6'h31, 32'h22222222);
        step();
        check("t5_rd_killed", s_rd, 1'b0);
        check("t5_busy_killed", s_busy, 1'b0);
        check("t5_rvalid_killed", s_rvalid, 2'b00);
        rst_n = 1'b1;
        step(); check("t5_first_gnt", s_gnt, 2'b01);
        wait_quiet();

        // random traffic with occasional resets
        rand_mode = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            step();
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end
        end
        rand_mode = 1'b0;
        p_hold = '0;
        wait_quiet();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
